alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (operands, result).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port alu_control  input  3  operation code as produced by the ALU decoder.
REQ-007 SHALL have port src_a  input  WIDTH  operand A.
REQ-008 SHALL have port src_b  input  WIDTH  operand B; bits [4:0] are the shift amount for shifts.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  WIDTH  operation result.
REQ-012 SHALL have ports zero, negative, carry, overflow  output  1 each  result flags.

Function
REQ-013 SHALL decode alu_control: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT (signed), 100 SLL, 110 SRL, 111 SRA.
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready = 1 only in IDLE.
REQ-015 SHALL capture alu_control, src_a, src_b on in_valid && in_ready; later input changes are ignored until next accept.
REQ-016 SHALL, for ADD/SUB/AND/OR/SLT, register result and flags at accept edge and enter DONE (out_valid high the cycle after accept).
REQ-017 SHALL, for shifts with shamt 0, enter DONE with result = src_a (latency 1).
REQ-018 SHALL, for shifts with shamt N>0, enter SHIFT, shift one bit per cycle with a down-counter, and enter DONE after N cycles (out_valid N+1 cycles after accept).
REQ-019 SHALL fill SLL/SRL vacated bits with 0 and SRA vacated bits with operand sign bit.
REQ-020 SHALL hold out_valid, result and all flags stable in DONE until out_valid && out_ready, then return to IDLE next cycle.
REQ-021 SHALL ignore in_valid while in SHIFT or DONE (no request lost: in_ready low).
REQ-022 SHALL compute SUB as src_a + ~src_b + 1; carry = carry-out of WIDTH-bit add (SUB: 1 means no borrow).
REQ-023 SHALL set overflow to signed overflow for ADD/SUB, 0 for all other operations; carry 0 for non-ADD/SUB.
REQ-024 SHALL set zero = (result == 0) and negative = result[WIDTH-1] for every operation.
REQ-025 SHALL produce SLT result 1 when signed src_a < signed src_b, else 0, zero-extended to WIDTH.

Reset
REQ-026 SHALL on rst force state IDLE, shift counter 0, out_valid 0, result 0, all flags 0, immediately and independent of clk.
REQ-027 SHALL abort any in-progress shift or pending result on rst mid-operation; no result is emitted for it.
REQ-028 SHALL drive in_ready 1 in the first cycle after rst deasserts.

Structure
REQ-029 SHALL place alu_control code constants and FSM state encodings in shared package alu_pkg, reused by the decoder.
REQ-030 SHALL implement the iterative shifter (operand register, counter, mode) as sub-module alu_shifter.

Verification
REQ-031 SHALL test ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow 1, negative 1, carry 0, out_valid 1 cycle after accept.
REQ-032 SHALL test SUB 5 - 5 -> result 0, zero 1, carry 1; SLT -1 vs 1 -> result 1.
REQ-033 SHALL test SRA 0x80000000 by 31 -> result 0xFFFFFFFF, out_valid exactly 32 cycles after accept; SLL by 0 -> latency 1.
REQ-034 SHALL test backpressure: out_ready low 5 cycles in DONE -> result/flags stable, in_ready 0, new in_valid ignored.
REQ-035 SHALL test rst asserted during SRL by 20 at cycle 10 -> out_valid 0, result 0 immediately; in_ready 1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: decoder operation codes, execution FSM states and
// the shift-amount width used by the iterative shifter.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLL = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SRA = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  localparam int SHAMT_W = 5;

  function automatic logic is_shift(input alu_ctrl_e c);
    return (c == ALU_SLL) || (c == ALU_SRL) || (c == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Iterative one-bit-per-cycle shifter: holds the operand, the remaining shift
// count and the shift mode; next_value is the value after the coming shift.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  alu_ctrl_e          mode_in,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   next_value,
  output logic               last
);

  logic [WIDTH-1:0]   value;
  logic [SHAMT_W-1:0] count;
  alu_ctrl_e          mode;

  always_comb begin
    next_value = '0;
    case (mode)
      ALU_SLL: next_value = {value[WIDTH-2:0], 1'b0};
      ALU_SRA: next_value = {value[WIDTH-1], value[WIDTH-1:1]};
      default: next_value = {1'b0, value[WIDTH-1:1]};
    endcase
  end

  // last is high during the cycle whose closing edge performs the final shift
  assign last = (count == SHAMT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      count <= '0;
      mode  <= ALU_SLL;
    end else if (load) begin
      value <= operand;
      count <= shamt;
      mode  <= mode_in;
    end else if (count != '0) begin
      value <= next_value;
      count <= count - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle arithmetic/logic ops, multi-cycle shifts,
// result held in DONE until the consumer takes it.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output alu_state_e       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid, once raised, holds its payload stable until that edge.
  alu_state_e         state;
  alu_ctrl_e          op;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;
  logic               start_shift;
  logic               sub;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   op_result;
  logic               op_carry;
  logic               op_ovf;
  logic [WIDTH-1:0]   sh_next;
  logic               sh_last;

  assign op          = alu_ctrl_e'(alu_control);
  assign shamt       = src_b[SHAMT_W-1:0];
  assign in_ready    = (state == ST_IDLE);
  assign out_valid   = (state == ST_DONE);
  assign dbg_state   = state;
  assign accept      = in_valid && in_ready;
  assign start_shift = accept && is_shift(op) && (shamt != '0);

  always_comb begin
    sub       = (op == ALU_SUB);
    b_eff     = sub ? ~src_b : src_b;
    sum       = {1'b0, src_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    op_result = '0;
    op_carry  = 1'b0;
    op_ovf    = 1'b0;
    case (op)
      ALU_ADD, ALU_SUB: begin
        op_result = sum[WIDTH-1:0];
        op_carry  = sum[WIDTH];
        op_ovf    = (src_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                    (sum[WIDTH-1] != src_a[WIDTH-1]);
      end
      ALU_AND: op_result = src_a & src_b;
      ALU_OR:  op_result = src_a | src_b;
      ALU_SLT: op_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      // shifts reaching here have a zero shift amount
      default: op_result = src_a;
    endcase
  end

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load       (start_shift),
    .mode_in    (op),
    .operand    (src_a),
    .shamt      (shamt),
    .next_value (sh_next),
    .last       (sh_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      result   <= '0;
      zero     <= 1'b0;
      negative <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_shift) begin
            state <= ST_SHIFT;
          end else if (accept) begin
            state    <= ST_DONE;
            result   <= op_result;
            zero     <= (op_result == '0);
            negative <= op_result[WIDTH-1];
            carry    <= op_carry;
            overflow <= op_ovf;
          end
        end
        ST_SHIFT: begin
          if (sh_last) begin
            state    <= ST_DONE;
            result   <= sh_next;
            zero     <= (sh_next == '0);
            negative <= sh_next[WIDTH-1];
            carry    <= 1'b0;
            overflow <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed vectors, backpressure and
// mid-shift reset scenarios.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   alu_control = 3'b000;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero, negative, carry, overflow;
  alu_state_e   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [2:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   flags;   // {zero, negative, carry, overflow}
    int           lat;
  } vec_t;

  vec_t vecs[15];

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .negative    (negative),
    .carry       (carry),
    .overflow    (overflow),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // drive one request; returns cycles from accept edge until out_valid
  task automatic issue(input logic [2:0] c, input logic [W-1:0] a,
                       input logic [W-1:0] b, output int lat);
    @(negedge clk);
    check("in_ready_before_issue", 64'(in_ready), 64'(1));
    in_valid    = 1'b1;
    alu_control = c;
    src_a       = a;
    src_b       = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    src_a    = '1;
    src_b    = '1;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic complete();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_after_take", 64'(out_valid), 64'(0));
  endtask

  initial begin
    int lat;
    logic [W-1:0] exp_res;
    logic [W-1:0] held;
    logic [3:0]   held_flags;
    int seen;

    //              ctrl    a             b             res           zncv     lat
    vecs[0]  = '{3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101, 1};
    vecs[1]  = '{3'b001, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1010, 1};
    vecs[2]  = '{3'b101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000, 1};
    vecs[3]  = '{3'b111, 32'h80000000, 32'd31,       32'hFFFFFFFF, 4'b0100, 32};
    vecs[4]  = '{3'b100, 32'h12345678, 32'd0,        32'h12345678, 4'b0000, 1};
    vecs[5]  = '{3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0100, 1};
    vecs[6]  = '{3'b011, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000, 1};
    vecs[7]  = '{3'b001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0100, 1};
    vecs[8]  = '{3'b100, 32'h00000001, 32'd4,        32'h00000010, 4'b0000, 5};
    vecs[9]  = '{3'b110, 32'hF0000000, 32'd4,        32'h0F000000, 4'b0000, 5};
    vecs[10] = '{3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010, 1};
    vecs[11] = '{3'b001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011, 1};
    vecs[12] = '{3'b101, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 4'b1000, 1};
    vecs[13] = '{3'b111, 32'h40000000, 32'd3,        32'h08000000, 4'b0000, 4};
    vecs[14] = '{3'b100, 32'h00000003, 32'hFFFFFFFF, 32'h80000000, 4'b0100, 32};

    // reset state
    #2;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_flags", 64'({zero, negative, carry, overflow}), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release_in_ready", 64'(in_ready), 64'(1));

    // directed vectors through the scoreboard
    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].res);
      issue(vecs[i].ctrl, vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      exp_res = exp_q.pop_front();
      check($sformatf("v%0d_result", i), 64'(result), 64'(exp_res));
      check($sformatf("v%0d_flags", i), 64'({zero, negative, carry, overflow}),
            64'(vecs[i].flags));
      check($sformatf("v%0d_in_ready_done", i), 64'(in_ready), 64'(0));
      complete();
    end

    // backpressure: hold out_ready low in DONE with a competing request
    issue(3'b000, 32'd3, 32'd4, lat);
    check("bp_latency", 64'(lat), 64'(1));
    held       = result;
    held_flags = {zero, negative, carry, overflow};
    check("bp_result", 64'(held), 64'(7));
    @(negedge clk);
    in_valid    = 1'b1;
    alu_control = 3'b001;
    src_a       = 32'd100;
    src_b       = 32'd1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_valid_%0d", k), 64'(out_valid), 64'(1));
      check($sformatf("bp_ready_%0d", k), 64'(in_ready), 64'(0));
      check($sformatf("bp_result_%0d", k), 64'(result), 64'(32'd7));
      check($sformatf("bp_flags_%0d", k), 64'({zero, negative, carry, overflow}),
            64'(held_flags));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_idle_ready", 64'(in_ready), 64'(1));
    check("bp_no_ghost_0", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
    check("bp_no_ghost_1", 64'(out_valid), 64'(0));

    issue(3'b000, 32'd1, 32'd1, lat);
    check("post_bp_result", 64'(result), 64'(2));
    check("post_bp_latency", 64'(lat), 64'(1));
    complete();

    // reset in the middle of SRL by 20
    @(negedge clk);
    in_valid    = 1'b1;
    alu_control = 3'b110;
    src_a       = 32'hFFFFFFFF;
    src_b       = 32'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_shift_state", 64'(dbg_state), 64'(ST_SHIFT));
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_result", 64'(result), 64'(0));
    check("mid_rst_flags", 64'({zero, negative, carry, overflow}), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_release_ready", 64'(in_ready), 64'(1));
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("mid_rst_no_result", 64'(seen), 64'(0));

    issue(3'b111, 32'h80000000, 32'd1, lat);
    check("post_rst_sra_result", 64'(result), 64'(32'hC0000000));
    check("post_rst_sra_latency", 64'(lat), 64'(2));
    complete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
